cell_writeback_router: RTL and testbench
========================================

// Module: cell_writeback_router
// PURPOSE
//  Consumes the {cell index, wrapped position} stream produced by the per-particle cell-index stage.
//  Assigns each live particle the next free slot in its destination cell and issues one write to the
//  banked position memory. At phase end, writes a null terminator into every non-full cell.
//  Sits between cell-index computation and the next timestep's cell position caches.
// PARAMETERS
//  N_CELL   27   number of cells; cell index is 0..N_CELL-1
//  DEPTH    64   slots per cell, power of 2
//  CELL_W   5    width of cell number, >= clog2(N_CELL)
//  SLOT_W   6    clog2(DEPTH)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 synchronous reset, active-high
//  phase_start  in   1                 pulse: clear all cell counters and begin accepting
//  phase_end    in   1                 pulse: upstream stream finished; begin terminator sweep
//  in_valid     in   1                 input beat valid
//  in_ready     out  1                 block can accept a beat
//  in_cidx      in   33                [31:0] unsigned cell index; [32] null flag
//  in_pos       in   97                [95:0] x,y,z fp32 wrapped position; [96] null flag
//  wr_en        out  1                 memory write strobe
//  wr_addr      out  CELL_W+SLOT_W     {cell, slot}
//  wr_data      out  97                word to write
//  busy         out  1                 state != IDLE
//  done         out  1                 one-cycle pulse when the sweep completes
//  ovf          out  1                 sticky: a particle was dropped because its cell was full
//  range_err    out  1                 sticky: a cell index >= N_CELL was dropped
//  ovf_cell     out  CELL_W            cell of the first overflow since phase_start
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; in_ready, wr_en, busy, done, ovf, range_err 0; ovf_cell 0;
//   wr_addr 0; wr_data 0.
//  FSM states: IDLE, RUN, SWEEP, FIN.
//   IDLE: phase_start -> RUN. Same cycle: clear all N_CELL counters, ovf, range_err, ovf_cell.
//   RUN: phase_end -> SWEEP. phase_start is ignored.
//   SWEEP: sweep index s = 0..N_CELL-1, one cell per cycle. After s = N_CELL-1 -> FIN.
//   FIN: done=1 for exactly one cycle -> IDLE.
//  Handshake:
//   - in_ready = (state == RUN).
//   - A beat is accepted when in_valid & in_ready.
//   - A beat accepted in the same cycle as phase_end is processed normally.
//  Accepted beat, with c = in_cidx[31:0] and null = in_cidx[32] | in_pos[96]:
//   - null=1: dropped; no write; no counter change.
//   - c >= N_CELL: dropped; range_err <= 1.
//   - cnt[c] == DEPTH: dropped; ovf <= 1; ovf_cell <= c only if ovf was 0.
//   - Otherwise: next cycle wr_en=1, wr_addr={c[CELL_W-1:0], cnt[c][SLOT_W-1:0]},
//     wr_data={1'b0, in_pos[95:0]}; cnt[c] <= cnt[c] + 1.
//   - Write latency is 1 cycle, fully registered. Back-to-back beats to the same cell get
//     consecutive slots (no hazard bubble).
//  Counters are SLOT_W+1 bits wide and saturate at DEPTH.
//  SWEEP, for cell s:
//   - If cnt[s] < DEPTH: next cycle wr_en=1, wr_addr={s, cnt[s]}, wr_data={1'b1, 96'b0}.
//   - Else no write. The cycle is still consumed.
//   - Sweep always takes N_CELL cycles.
//  wr_en is 0 in every cycle not listed above. wr_addr and wr_data hold their last values when wr_en=0.
//  rst asserted in any state (mid-RUN or mid-SWEEP): returns to reset values next edge.
//   Any pending registered write is cancelled (wr_en=0).
//  phase_end while in IDLE is ignored.
// TESTING
//  T1 reset: hold rst 2 cycles in RUN with in_valid=1 -> all outputs 0 next edge; state IDLE.
//  T2 basic: start; beats to cells 0,0,5 (pos 1.0,2.0,3.0) -> writes at addr 0,1,320
//   (5*64) one cycle after each accept; end -> 27 terminator writes, cell0 at slot 2, done after sweep.
//  T3 null: beat with in_cidx[32]=1 or in_pos[96]=1 -> no wr_en; cnt unchanged; later beat to the
//   same cell lands at slot 0.
//  T4 overflow: 65 beats to cell 26 -> 64 writes (slots 0..63); ovf=1; ovf_cell=26;
//   sweep skips cell 26 (26 terminator writes).
//  T5 range: in_cidx=27 -> no write; range_err=1; clears on next phase_start.
//  T6 edge: phase_end with an accepted beat in the same cycle -> beat written; then sweep;
//   rst mid-sweep -> no further writes, done never pulses.

Source files
------------

// File: rtl/cell_writeback_router_if.sv
`default_nettype none
// ============================================================================
// Module      : cell_writeback_router_if
// Description : Bundles the input beat handshake ({cell index, position}
//               stream) and the banked position-memory write port used by
//               cell_writeback_router.
//               master : upstream producer / memory side (drives in_*,
//                        observes in_ready and wr_*)
//               slave  : the router (accepts in_*, drives in_ready and wr_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface cell_writeback_router_if #(
    parameter int CELL_W = 5,
    parameter int SLOT_W = 6
);
    logic                       in_valid;
    logic                       in_ready;
    logic [32:0]                in_cidx;   // [32] null flag, [31:0] cell index
    logic [96:0]                in_pos;    // [96] null flag, [95:0] x,y,z fp32
    logic                       wr_en;
    logic [CELL_W+SLOT_W-1:0]   wr_addr;   // {cell, slot}
    logic [96:0]                wr_data;

    modport master (
        output in_valid, in_cidx, in_pos,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_cidx, in_pos,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/cell_writeback_router.sv
`default_nettype none
// ============================================================================
// Module      : cell_writeback_router
// Description : Assigns each live particle the next free slot of its
//               destination cell and issues one registered write to the
//               banked position memory. At phase end a sweep writes a null
//               terminator into every cell that is not full.
// Ports       : clk, rst             clock / synchronous active-high reset
//               phase_start          pulse, clears counters, enters RUN
//               phase_end            pulse, ends the stream, starts the sweep
//               bus (slave)          input beat handshake + memory write port
//               busy                 state != IDLE
//               done                 one-cycle pulse when the sweep completes
//               ovf / ovf_cell       sticky overflow flag / first overflowing cell
//               range_err            sticky out-of-range cell index flag
// Revision    : 1.0 - initial release
// ============================================================================
module cell_writeback_router #(
    parameter int N_CELL = 27,
    parameter int DEPTH  = 64,
    parameter int CELL_W = 5,
    parameter int SLOT_W = 6
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               phase_start,
    input  wire logic               phase_end,
    cell_writeback_router_if.slave  bus,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic                    range_err,
    output logic [CELL_W-1:0]       ovf_cell
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_SWEEP = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [SLOT_W:0]   c_DEPTH     = (SLOT_W+1)'(DEPTH);
    localparam logic [CELL_W-1:0] c_LAST_CELL = CELL_W'(N_CELL - 1);
    localparam logic [31:0]       c_N_CELL    = 32'(N_CELL);

    state_t                     r_state;
    logic [SLOT_W:0]            r_cnt [N_CELL];
    logic [CELL_W-1:0]          r_sweep;
    logic                       r_wr_en;
    logic [CELL_W+SLOT_W-1:0]   r_wr_addr;
    logic [96:0]                r_wr_data;
    logic                       r_ovf;
    logic                       r_range_err;
    logic [CELL_W-1:0]          r_ovf_cell;

    logic                       w_accept;
    logic                       w_null;
    logic                       w_range;
    logic [CELL_W-1:0]          w_cell;
    logic [SLOT_W:0]            w_cnt;
    logic [SLOT_W:0]            w_sweep_cnt;

    assign w_accept    = bus.in_valid && (r_state == S_RUN);
    assign w_null      = bus.in_cidx[32] | bus.in_pos[96];
    assign w_range     = (bus.in_cidx[31:0] >= c_N_CELL);
    assign w_cell      = bus.in_cidx[CELL_W-1:0];
    // Only consumed when w_range is clear, so the index is always in bounds.
    assign w_cnt       = w_range ? '0 : r_cnt[w_cell];
    assign w_sweep_cnt = r_cnt[r_sweep];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sweep     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_ovf       <= 1'b0;
            r_range_err <= 1'b0;
            r_ovf_cell  <= '0;
            for (int i = 0; i < N_CELL; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // Strobe defaults low; only an accepted live beat or a sweep
            // step on a non-full cell raises it for one cycle.
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (phase_start) begin
                        r_state     <= S_RUN;
                        r_ovf       <= 1'b0;
                        r_range_err <= 1'b0;
                        r_ovf_cell  <= '0;
                        for (int i = 0; i < N_CELL; i++) begin
                            r_cnt[i] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // A beat arriving alongside phase_end is still processed.
                    if (w_accept && !w_null) begin
                        if (w_range) begin
                            r_range_err <= 1'b1;
                        end else if (w_cnt == c_DEPTH) begin
                            r_ovf <= 1'b1;
                            if (!r_ovf) begin
                                r_ovf_cell <= w_cell;
                            end
                        end else begin
                            r_wr_en       <= 1'b1;
                            r_wr_addr     <= {w_cell, w_cnt[SLOT_W-1:0]};
                            r_wr_data     <= {1'b0, bus.in_pos[95:0]};
                            r_cnt[w_cell] <= w_cnt + 1'b1;
                        end
                    end
                    if (phase_end) begin
                        r_state <= S_SWEEP;
                        r_sweep <= '0;
                    end
                end
                S_SWEEP: begin
                    if (w_sweep_cnt < c_DEPTH) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= {r_sweep, w_sweep_cnt[SLOT_W-1:0]};
                        r_wr_data <= {1'b1, 96'b0};
                    end
                    if (r_sweep == c_LAST_CELL) begin
                        r_state <= S_FIN;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_RUN);
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FIN);
    assign ovf          = r_ovf;
    assign range_err    = r_range_err;
    assign ovf_cell     = r_ovf_cell;

endmodule
`default_nettype wire

// File: tb/tb_cell_writeback_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_cell_writeback_router
// Description : Self-checking bench for cell_writeback_router. A reference
//               model of the per-cell counters predicts every memory write
//               into a scoreboard queue; a monitor pops and compares on each
//               observed write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_writeback_router;

    localparam int N_CELL = 27;
    localparam int DEPTH  = 64;
    localparam int CELL_W = 5;
    localparam int SLOT_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              phase_start;
    logic              phase_end;
    logic              busy;
    logic              done;
    logic              ovf;
    logic              range_err;
    logic [CELL_W-1:0] ovf_cell;

    cell_writeback_router_if #(.CELL_W(CELL_W), .SLOT_W(SLOT_W)) bus ();

    cell_writeback_router #(
        .N_CELL (N_CELL),
        .DEPTH  (DEPTH),
        .CELL_W (CELL_W),
        .SLOT_W (SLOT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .phase_start (phase_start),
        .phase_end   (phase_end),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf),
        .range_err   (range_err),
        .ovf_cell    (ovf_cell)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [107:0] sb_q [$];         // {addr[10:0], data[96:0]}
    int           m_cnt [N_CELL];
    bit           m_ovf;
    bit           m_rng;
    int           m_ovf_cell;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write_qsize", 128'(sb_q.size()), 128'd1);
            end else begin
                logic [107:0] e;
                e = sb_q.pop_front();
                check("wr_addr", 128'(bus.wr_addr), 128'(e[107:97]));
                check("wr_data", 128'(bus.wr_data), 128'(e[96:0]));
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < N_CELL; i++) m_cnt[i] = 0;
        m_ovf      = 1'b0;
        m_rng      = 1'b0;
        m_ovf_cell = 0;
    endtask

    task automatic model_beat(input logic [32:0] cidx, input logic [96:0] pos);
        int c;
        logic [10:0] a;
        c = int'(cidx[31:0]);
        if (cidx[32] || pos[96]) return;
        if (cidx[31:0] >= 32'(N_CELL)) begin
            m_rng = 1'b1;
        end else if (m_cnt[c] == DEPTH) begin
            if (!m_ovf) m_ovf_cell = c;
            m_ovf = 1'b1;
        end else begin
            a = 11'(c * DEPTH + m_cnt[c]);
            sb_q.push_back({a, 1'b0, pos[95:0]});
            m_cnt[c]++;
        end
    endtask

    task automatic push_terminators();
        logic [10:0] a;
        for (int s = 0; s < N_CELL; s++) begin
            if (m_cnt[s] < DEPTH) begin
                a = 11'(s * DEPTH + m_cnt[s]);
                sb_q.push_back({a, 1'b1, 96'b0});
            end
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic start_phase();
        phase_start = 1'b1;
        model_clear();
        @(posedge clk); #1;
        phase_start = 1'b0;
    endtask

    task automatic send_beat(input logic [32:0] cidx, input logic [96:0] pos);
        check("in_ready", 128'(bus.in_ready), 128'd1);
        bus.in_valid = 1'b1;
        bus.in_cidx  = cidx;
        bus.in_pos   = pos;
        model_beat(cidx, pos);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic end_phase(input bit with_beat, input logic [32:0] cidx, input logic [96:0] pos);
        phase_end = 1'b1;
        if (with_beat) begin
            bus.in_valid = 1'b1;
            bus.in_cidx  = cidx;
            bus.in_pos   = pos;
            model_beat(cidx, pos);
        end
        push_terminators();
        @(posedge clk); #1;
        phase_end    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 128'(done), 128'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(done), 128'd0);
        check({tag, "_sb_empty"}, 128'(sb_q.size()), 128'd0);
        check({tag, "_busy_idle"}, 128'(busy), 128'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [96:0] fpos(input logic [31:0] x);
        return {1'b0, 32'h0, 32'h0, x};
    endfunction

    initial begin
        int n_done;
        rst          = 1'b1;
        phase_start  = 1'b0;
        phase_end    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_cidx  = '0;
        bus.in_pos   = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy",   128'(busy),        128'd0);
        check("rst_ready",  128'(bus.in_ready), 128'd0);
        check("rst_wr_en",  128'(bus.wr_en),   128'd0);
        check("rst_ovf",    128'(ovf),         128'd0);
        check("rst_rng",    128'(range_err),   128'd0);

        // phase_end while idle must not start anything.
        phase_end = 1'b1;
        @(posedge clk); #1;
        phase_end = 1'b0;
        @(posedge clk); #1;
        check("idle_pend_busy", 128'(busy), 128'd0);

        // T2 basic
        start_phase();
        check("run_busy", 128'(busy), 128'd1);
        send_beat(33'd0, fpos(32'h3F80_0000));
        send_beat(33'd0, fpos(32'h4000_0000));
        send_beat(33'd5, fpos(32'h4040_0000));
        end_phase(1'b0, '0, '0);
        wait_done("basic");

        // T3 null + T4 overflow in one phase
        start_phase();
        send_beat({1'b1, 32'd4}, fpos(32'h1111_1111));
        send_beat(33'd4, {1'b1, 96'h2222});
        send_beat(33'd4, fpos(32'h3333_3333));
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_beat(33'd26, fpos(32'h4100_0000 + 32'(i)));
        end
        send_beat(33'd26, fpos(32'hDEAD_BEEF));
        check("ovf_flag",  128'(ovf),       128'(m_ovf));
        check("ovf_cell",  128'(ovf_cell),  128'(m_ovf_cell));
        check("ovf_no_rng", 128'(range_err), 128'(m_rng));
        end_phase(1'b0, '0, '0);
        wait_done("ovf");

        // T5 range
        start_phase();
        check("ovf_cleared", 128'(ovf), 128'd0);
        send_beat(33'd27, fpos(32'h5555_5555));
        send_beat(33'hFFFF_FFFF, fpos(32'h6666_6666));
        @(posedge clk); #1;
        check("range_err_set", 128'(range_err), 128'(m_rng));
        send_beat(33'd26, fpos(32'h7777_7777));
        end_phase(1'b0, '0, '0);
        wait_done("range");
        start_phase();
        check("range_err_clr", 128'(range_err), 128'd0);

        // T6 beat on phase_end, then reset mid-sweep
        send_beat(33'd10, fpos(32'h0A0A_0A0A));
        end_phase(1'b1, 33'd10, fpos(32'h0B0B_0B0B));
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        model_clear();
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("rst_sweep_no_done", 128'(n_done), 128'd0);
        check("rst_sweep_busy",    128'(busy),   128'd0);

        // T1 reset while in RUN with in_valid held high
        @(posedge clk); #1;
        start_phase();
        send_beat(33'd1, fpos(32'h1234_5678));
        send_beat(33'd30, fpos(32'h0));
        check("pre_rst_rng", 128'(range_err), 128'd1);
        bus.in_valid = 1'b1;
        bus.in_cidx  = 33'd2;
        bus.in_pos   = fpos(32'h9999_9999);
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t1_busy",    128'(busy),          128'd0);
        check("t1_ready",   128'(bus.in_ready),  128'd0);
        check("t1_wr_en",   128'(bus.wr_en),     128'd0);
        check("t1_wr_addr", 128'(bus.wr_addr),   128'd0);
        check("t1_wr_data", 128'(bus.wr_data),   128'd0);
        check("t1_done",    128'(done),          128'd0);
        check("t1_ovf",     128'(ovf),           128'd0);
        check("t1_rng",     128'(range_err),     128'd0);
        check("t1_ovfcell", 128'(ovf_cell),      128'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("final_sb_empty", 128'(sb_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
